// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-style control FSM:
// state codes, opcodes, ALU ops, PC/reg-select codes, instr classes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_MEM = 4'd2,
    S_MEM     = 4'd3,
    S_WB_LD   = 4'd4,
    S_EXE_BR  = 4'd5,
    S_EXE_R   = 4'd6,
    S_WB_R    = 4'd7,
    S_HALT    = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_SW, C_LW, C_BEQ, C_BNE,
    C_J, C_JR, C_JAL, C_HALT, C_ILL
  } cls_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [1:0] EXT_SHAMT = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_SIGN  = 2'b10;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;

  localparam logic [1:0] RO_R31 = 2'b00;
  localparam logic [1:0] RO_RT  = 2'b01;
  localparam logic [1:0] RO_RD  = 2'b10;

endpackage

// File: rtl/mc_op_decode.sv
// Opcode decoder: opcode -> instruction class plus ALU-path fields.
// Ports: opcode in; cls, aluop, ext_sel, alu_src_b, reg_out out.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output cls_t       cls,
  output logic [2:0] aluop,
  output logic [1:0] ext_sel,
  output logic       alu_src_b,
  output logic [1:0] reg_out
);

  always_comb begin
    cls       = C_ILL;
    aluop     = ALU_ADD;
    ext_sel   = EXT_SHAMT;
    alu_src_b = 1'b0;
    reg_out   = RO_RD;
    case (opcode)
      OP_ADD, OP_MOVE: cls = C_ALU;
      OP_SUB: begin
        cls   = C_ALU;
        aluop = ALU_SUB;
      end
      OP_SLT: begin
        cls   = C_ALU;
        aluop = ALU_SLT;
      end
      OP_OR: begin
        cls   = C_ALU;
        aluop = ALU_OR;
      end
      OP_AND: begin
        cls   = C_ALU;
        aluop = ALU_AND;
      end
      OP_ADDI: begin
        cls       = C_ALU;
        alu_src_b = 1'b1;
        ext_sel   = EXT_SIGN;
        reg_out   = RO_RT;
      end
      OP_ORI: begin
        cls       = C_ALU;
        aluop     = ALU_OR;
        alu_src_b = 1'b1;
        ext_sel   = EXT_ZERO;
        reg_out   = RO_RT;
      end
      OP_SLL: begin
        cls       = C_ALU;
        aluop     = ALU_SLL;
        alu_src_b = 1'b1;
      end
      OP_SW:   cls = C_SW;
      OP_LW:   cls = C_LW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_J:    cls = C_J;
      OP_JR:   cls = C_JR;
      OP_JAL:  cls = C_JAL;
      OP_HALT: cls = C_HALT;
      default: cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM with retired-instruction counter.
// In: clk, RST, opcode, zero, mem_ready. Out: datapath controls, state, halted, illegal, instr_count.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W       = 3,
  parameter int CNT_W         = 32,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic               ALUSrcB,
  output logic               ALUM2Reg,
  output logic               WrRegData,
  output logic               DataMemEn,
  output logic               DataMemRW,
  output logic [1:0]         ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegOut,
  output logic               halted,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   instr_count
);

  state_t     state_q, state_d;
  cls_t       cls;
  logic [2:0] dec_aluop, alu_op;
  logic [1:0] dec_ext, dec_ro;
  logic       dec_sb;
  logic       mem_done, taken;

  mc_op_decode u_dec (
    .opcode    (opcode),
    .cls       (cls),
    .aluop     (dec_aluop),
    .ext_sel   (dec_ext),
    .alu_src_b (dec_sb),
    .reg_out   (dec_ro)
  );

  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;
  assign taken    = (cls == C_BEQ && zero) || (cls == C_BNE && !zero);
  assign state    = state_q;
  assign ALUOp    = ALUOP_W'(alu_op);

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (cls)
          C_ALU:       state_d = S_EXE_R;
          C_SW, C_LW:  state_d = S_EXE_MEM;
          C_BEQ, C_BNE: state_d = S_EXE_BR;
          C_HALT:      state_d = S_HALT;
          default:     state_d = S_IF;
        endcase
      end
      S_EXE_R:   state_d = S_WB_R;
      S_EXE_MEM: state_d = S_MEM;
      S_MEM: begin
        if (!mem_done)
          state_d = S_MEM;
        else if (cls == C_SW)
          state_d = S_IF;
        else
          state_d = S_WB_LD;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Reset forces every control low at once, even mid-access.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    WrRegData = 1'b0;
    DataMemEn = 1'b0;
    DataMemRW = 1'b0;
    ExtSel    = EXT_SHAMT;
    alu_op    = ALU_ADD;
    PCSrc     = PC_NEXT;
    RegOut    = RO_R31;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (!RST) begin
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          case (cls)
            C_J: begin
              PCWre = 1'b1;
              PCSrc = PC_JMP;
            end
            C_JR: begin
              PCWre = 1'b1;
              PCSrc = PC_JR;
            end
            C_JAL: begin
              PCWre  = 1'b1;
              PCSrc  = PC_JMP;
              RegWre = 1'b1;
              RegOut = RO_R31;
            end
            C_ILL: begin
              illegal = 1'b1;
              PCWre   = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXE_R, S_WB_R: begin
          alu_op  = dec_aluop;
          ALUSrcB = dec_sb;
          ExtSel  = dec_ext;
          if (state_q == S_WB_R) begin
            RegWre    = 1'b1;
            WrRegData = 1'b1;
            RegOut    = dec_ro;
            PCWre     = 1'b1;
          end
        end
        S_EXE_MEM, S_MEM, S_WB_LD: begin
          ALUSrcB = 1'b1;
          ExtSel  = EXT_SIGN;
          if (state_q == S_MEM) begin
            DataMemEn = 1'b1;
            DataMemRW = (cls == C_SW);
            PCWre     = mem_done && (cls == C_SW);
          end
          if (state_q == S_WB_LD) begin
            RegWre    = 1'b1;
            ALUM2Reg  = 1'b1;
            WrRegData = 1'b1;
            RegOut    = RO_RT;
            PCWre     = 1'b1;
          end
        end
        S_EXE_BR: begin
          alu_op = ALU_CMP;
          ExtSel = EXT_SIGN;
          PCWre  = 1'b1;
          PCSrc  = taken ? PC_BR : PC_NEXT;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_IF;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (PCWre && !illegal)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: table of instructions plus
// hand-written reset/halt/wrap sequences, scoreboard of expected outputs.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       pcwre, irwre, regwre, alusrcb, alum2reg, wrregdata, dmen, dmrw;
    logic [1:0] extsel;
    logic [2:0] aluop;
    logic [1:0] pcsrc, regout;
    logic       halted, illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         nwait;
    int         cyc;
    int         ret;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, zero, mem_ready;
  logic [5:0] opcode;

  logic a_pcwre, a_irwre, a_regwre, a_sb, a_m2r, a_wrd, a_men, a_mrw, a_halt, a_ill;
  logic [1:0] a_ext, a_pcsrc, a_ro;
  logic [2:0] a_aluop;
  logic [3:0] a_state;
  logic [31:0] a_cnt;

  logic b_pcwre, b_irwre, b_regwre, b_sb, b_m2r, b_wrd, b_men, b_mrw, b_halt, b_ill;
  logic [1:0] b_ext, b_pcsrc, b_ro;
  logic [2:0] b_aluop;
  logic [3:0] b_state;
  logic [3:0] b_cnt;

  mc_ctrl_fsm dut (
    .clk(clk), .RST(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWre(a_pcwre), .IRWre(a_irwre), .RegWre(a_regwre), .ALUSrcB(a_sb),
    .ALUM2Reg(a_m2r), .WrRegData(a_wrd), .DataMemEn(a_men), .DataMemRW(a_mrw),
    .ExtSel(a_ext), .ALUOp(a_aluop), .PCSrc(a_pcsrc), .RegOut(a_ro),
    .halted(a_halt), .illegal(a_ill), .state(a_state), .instr_count(a_cnt)
  );

  mc_ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .RST(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWre(b_pcwre), .IRWre(b_irwre), .RegWre(b_regwre), .ALUSrcB(b_sb),
    .ALUM2Reg(b_m2r), .WrRegData(b_wrd), .DataMemEn(b_men), .DataMemRW(b_mrw),
    .ExtSel(b_ext), .ALUOp(b_aluop), .PCSrc(b_pcsrc), .RegOut(b_ro),
    .halted(b_halt), .illegal(b_ill), .state(b_state), .instr_count(b_cnt)
  );

  outs_t       sb_q[$];
  int          applied = 0;
  int          miscompares = 0;
  logic [31:0] exp_cnt;
  int          ms;
  vec_t        vt[17];

  function automatic outs_t got_a();
    outs_t o;
    o = {a_pcwre, a_irwre, a_regwre, a_sb, a_m2r, a_wrd, a_men, a_mrw,
         a_ext, a_aluop, a_pcsrc, a_ro, a_halt, a_ill, a_state};
    return o;
  endfunction

  function automatic outs_t got_b();
    outs_t o;
    o = {b_pcwre, b_irwre, b_regwre, b_sb, b_m2r, b_wrd, b_men, b_mrw,
         b_ext, b_aluop, b_pcsrc, b_ro, b_halt, b_ill, b_state};
    return o;
  endfunction

  // Expected outputs and next state, written from the instruction set table.
  function automatic outs_t model(input int st, input logic [5:0] op,
                                  input logic z, input logic mr, output int nx);
    outs_t o;
    logic [2:0] a;
    logic sb;
    logic [1:0] ex, ro;
    o = '0;
    o.state = 4'(st);
    a = 3'd0; sb = 1'b0; ex = 2'd0; ro = 2'b10; nx = 0;
    case (op)
      6'b000001: a = 3'b001;
      6'b000010: begin sb = 1'b1; ex = 2'b10; ro = 2'b01; end
      6'b010000: a = 3'b101;
      6'b010001: a = 3'b110;
      6'b010010: begin a = 3'b101; sb = 1'b1; ex = 2'b01; ro = 2'b01; end
      6'b011000: begin a = 3'b100; sb = 1'b1; end
      6'b100111: a = 3'b010;
      default: ;
    endcase
    case (st)
      0: begin o.irwre = 1'b1; nx = 1; end
      1: begin
        case (op)
          6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
          6'b010010, 6'b011000, 6'b100000, 6'b100111: nx = 6;
          6'b110000, 6'b110001: nx = 2;
          6'b110100, 6'b110101: nx = 5;
          6'b111000: begin o.pcwre = 1'b1; o.pcsrc = 2'b11; end
          6'b111001: begin o.pcwre = 1'b1; o.pcsrc = 2'b10; end
          6'b111010: begin
            o.pcwre = 1'b1; o.pcsrc = 2'b11; o.regwre = 1'b1; o.regout = 2'b00;
          end
          6'b111111: nx = 8;
          default: begin o.illegal = 1'b1; o.pcwre = 1'b1; end
        endcase
      end
      6: begin o.aluop = a; o.alusrcb = sb; o.extsel = ex; nx = 7; end
      7: begin
        o.aluop = a; o.alusrcb = sb; o.extsel = ex;
        o.regwre = 1'b1; o.wrregdata = 1'b1; o.regout = ro; o.pcwre = 1'b1;
      end
      2: begin o.alusrcb = 1'b1; o.extsel = 2'b10; nx = 3; end
      3: begin
        o.alusrcb = 1'b1; o.extsel = 2'b10; o.dmen = 1'b1;
        o.dmrw = (op == 6'b110000);
        if (mr) begin
          o.pcwre = (op == 6'b110000);
          nx = (op == 6'b110000) ? 0 : 4;
        end else nx = 3;
      end
      4: begin
        o.alusrcb = 1'b1; o.extsel = 2'b10; o.regwre = 1'b1; o.alum2reg = 1'b1;
        o.wrregdata = 1'b1; o.regout = 2'b01; o.pcwre = 1'b1;
      end
      5: begin
        o.aluop = 3'b111; o.extsel = 2'b10; o.pcwre = 1'b1;
        o.pcsrc = ((op == 6'b110100 && z) || (op == 6'b110101 && !z)) ? 2'b01 : 2'b00;
      end
      8: begin o.halted = 1'b1; nx = 8; end
      default: nx = 0;
    endcase
    return o;
  endfunction

  task automatic chk(input string nm, input outs_t got, input outs_t exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive, predict, compare at negedge.
  task automatic step(input logic [5:0] op, input logic z, input logic mr);
    outs_t e;
    int nx;
    opcode = op; zero = z; mem_ready = mr;
    sb_q.push_back(model(ms, op, z, mr, nx));
    @(negedge clk);
    e = sb_q.pop_front();
    chk("outs", got_a(), e);
    chk("outs_cnt4", got_b(), e);
    chk_val("count", a_cnt, exp_cnt);
    chk_val("count4", {28'd0, b_cnt}, exp_cnt & 32'hf);
    @(posedge clk); #1;
    if (e.pcwre && !e.illegal) exp_cnt = exp_cnt + 1;
    ms = nx;
  endtask

  task automatic run_vec(input vec_t v);
    int cycles, mw;
    logic [31:0] c0;
    logic mr;
    cycles = 0; mw = 0; c0 = exp_cnt;
    do begin
      mr = 1'b0;
      if (ms == 3) begin
        mr = (mw >= v.nwait);
        mw++;
      end
      step(v.op, v.z, mr);
      cycles++;
    end while (ms != 0 && cycles < 20);
    chk_val("cycles", 32'(cycles), 32'(v.cyc));
    chk_val("retired", exp_cnt - c0, 32'(v.ret));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ms = 0;
    exp_cnt = 0;
  endtask

  initial begin
    outs_t zexp;
    vt[0]  = '{6'b000000, 1'b0, 0, 4, 1};
    vt[1]  = '{6'b000001, 1'b0, 0, 4, 1};
    vt[2]  = '{6'b000010, 1'b0, 0, 4, 1};
    vt[3]  = '{6'b010000, 1'b0, 0, 4, 1};
    vt[4]  = '{6'b010001, 1'b0, 0, 4, 1};
    vt[5]  = '{6'b010010, 1'b0, 0, 4, 1};
    vt[6]  = '{6'b011000, 1'b0, 0, 4, 1};
    vt[7]  = '{6'b100000, 1'b0, 0, 4, 1};
    vt[8]  = '{6'b100111, 1'b0, 0, 4, 1};
    vt[9]  = '{6'b110000, 1'b0, 0, 4, 1};
    vt[10] = '{6'b110001, 1'b0, 2, 7, 1};
    vt[11] = '{6'b110100, 1'b1, 0, 3, 1};
    vt[12] = '{6'b110101, 1'b1, 0, 3, 1};
    vt[13] = '{6'b110100, 1'b0, 0, 3, 1};
    vt[14] = '{6'b111000, 1'b0, 0, 2, 1};
    vt[15] = '{6'b111010, 1'b0, 0, 2, 1};
    vt[16] = '{6'b001111, 1'b0, 0, 2, 0};

    rst = 1'b1; opcode = 6'b110000; zero = 1'b0; mem_ready = 1'b1;
    exp_cnt = 0; ms = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    zexp = '0;
    chk("reset_outs", got_a(), zexp);
    chk_val("reset_count", a_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);
    step(6'b111001, 1'b0, 1'b0);
    step(6'b111001, 1'b0, 1'b0);

    // Reset asserted in MEM of a store that would otherwise complete.
    step(6'b110000, 1'b0, 1'b0);
    step(6'b110000, 1'b0, 1'b0);
    step(6'b110000, 1'b0, 1'b0);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    zexp = '0;
    zexp.state = 4'd3;
    chk("rst_in_mem", got_a(), zexp);
    @(posedge clk); #1;
    rst = 1'b0; ms = 0; exp_cnt = 0;
    step(6'b110000, 1'b0, 1'b0);

    // Halt holds until reset.
    do_reset();
    step(6'b111111, 1'b0, 1'b0);
    step(6'b111111, 1'b0, 1'b0);
    repeat (12) step(6'b111111, 1'b0, 1'b1);
    do_reset();
    step(6'b000000, 1'b0, 1'b0);

    // 16 retirements wrap the 4-bit counter.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(6'b111000, 1'b0, 1'b0);
      step(6'b111000, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk_val("wrap4", {28'd0, b_cnt}, 0);
    chk_val("count16", a_cnt, 16);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
